// File: rtl/wb_soc_ram_pkg.sv
// wb_soc_ram_pkg: shared types and constants for the Wishbone RAM slave
package wb_soc_ram_pkg;
  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_SEL_WIDTH  = 4;
  typedef enum logic [1:0] {IDLE, RD, WR, ACK} state_t;
endpackage

// File: rtl/wb_soc_ram_sel_merge.sv
// wb_soc_ram_sel_merge: per-byte-lane merge of new write data over the old RAM word
//   i_new    : incoming write data
//   i_old    : current RAM word
//   i_sel    : byte-lane enables, lane k taken from i_new when set
//   o_merged : merged word
module wb_soc_ram_sel_merge
  import wb_soc_ram_pkg::*;
(
  input  logic [WB_DATA_WIDTH-1:0] i_new,
  input  logic [WB_DATA_WIDTH-1:0] i_old,
  input  logic [WB_SEL_WIDTH-1:0]  i_sel,
  output logic [WB_DATA_WIDTH-1:0] o_merged
);
  for (genvar k = 0; k < WB_SEL_WIDTH; k++) begin : g_lane
    assign o_merged[8*k +: 8] = i_sel[k] ? i_new[8*k +: 8] : i_old[8*k +: 8];
  end
endmodule

// File: rtl/wb_soc_ram_slave.sv
// wb_soc_ram_slave: Wishbone classic slave in front of a registered-address single-port RAM
//   wb_clk_i / wb_rst_n_i : clock, asynchronous active-low reset
//   wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i (byte address), wb_sel_i, wb_dat_i : bus request
//   wb_dat_o, wb_ack_o, wb_err_o : bus response (ack/err one cycle, two edges after accept)
//   ram_addr_o, ram_data_o, ram_we_o, ram_q_i : RAM port; ram_q_i reflects the address of the previous edge
//   Optional macro WB_SOC_RAM_SLAVE_ERR_EN: out-of-range or misaligned addresses answer with err, no RAM write.
//   Writes are read-modify-write so partial byte lanes need only a full-word RAM.
module wb_soc_ram_slave
  import wb_soc_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_n_i,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_we_i,
  input  logic [31:0]              wb_adr_i,
  input  logic [WB_SEL_WIDTH-1:0]  wb_sel_i,
  input  logic [WB_DATA_WIDTH-1:0] wb_dat_i,
  output logic [WB_DATA_WIDTH-1:0] wb_dat_o,
  output logic                     wb_ack_o,
  output logic                     wb_err_o,
  output logic [ADDR_WIDTH-1:0]    ram_addr_o,
  output logic [WB_DATA_WIDTH-1:0] ram_data_o,
  output logic                     ram_we_o,
  input  logic [WB_DATA_WIDTH-1:0] ram_q_i
);
  state_t                   r_state;
  logic [ADDR_WIDTH-1:0]    r_adr;
  logic [WB_SEL_WIDTH-1:0]  r_sel;
  logic [WB_DATA_WIDTH-1:0] r_dat;
  logic [WB_DATA_WIDTH-1:0] r_dat_o;
  logic                     r_bad;
  logic                     r_ack;
  logic                     r_err;
  logic                     w_bad;
  logic [WB_DATA_WIDTH-1:0] w_merged;
`ifdef WB_SOC_RAM_SLAVE_ERR_EN
  assign w_bad = (|wb_adr_i[31:ADDR_WIDTH+2]) | (|wb_adr_i[1:0]);
`else
  logic w_unused;
  assign w_bad    = 1'b0;
  assign w_unused = &{1'b0, wb_adr_i[31:ADDR_WIDTH+2], wb_adr_i[1:0]};
`endif
  wb_soc_ram_sel_merge u_merge (
    .i_new    (r_dat),
    .i_old    (ram_q_i),
    .i_sel    (r_sel),
    .o_merged (w_merged)
  );
  // In IDLE the RAM sees the live bus address so read data is ready during RD.
  assign ram_addr_o = (r_state == IDLE) ? wb_adr_i[ADDR_WIDTH+1:2] : r_adr;
  assign ram_data_o = w_merged;
  // A dropped cycle, empty lane mask or rejected address must never reach the RAM.
  assign ram_we_o   = (r_state == WR) && wb_cyc_i && (|r_sel) && !r_bad;
  assign wb_dat_o   = r_dat_o;
  assign wb_ack_o   = r_ack;
  assign wb_err_o   = r_err;
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state <= IDLE;
      r_adr   <= '0;
      r_sel   <= '0;
      r_dat   <= '0;
      r_dat_o <= '0;
      r_bad   <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ack <= 1'b0;
          r_err <= 1'b0;
          if (wb_cyc_i && wb_stb_i) begin
            r_adr   <= wb_adr_i[ADDR_WIDTH+1:2];
            r_sel   <= wb_sel_i;
            r_dat   <= wb_dat_i;
            r_bad   <= w_bad;
            r_state <= wb_we_i ? WR : RD;
          end
        end
        RD: begin
          if (!wb_cyc_i) r_state <= IDLE;
          else begin
            if (!r_bad) r_dat_o <= ram_q_i;
            r_ack   <= !r_bad;
            r_err   <= r_bad;
            r_state <= ACK;
          end
        end
        WR: begin
          if (!wb_cyc_i) r_state <= IDLE;
          else begin
            r_ack   <= !r_bad;
            r_err   <= r_bad;
            r_state <= ACK;
          end
        end
        ACK: begin
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_soc_ram_slave.sv
// tb_wb_soc_ram_slave: scoreboard bench for wb_soc_ram_slave with a behavioural RAM
module tb_wb_soc_ram_slave;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, dat_i = '0;
  logic [3:0]  sel = '0;
  logic [31:0] dat_o;
  logic        ack, err;
  logic [5:0]  ram_addr;
  logic [31:0] ram_data, ram_q;
  logic        ram_we;
  logic [31:0] mem [0:63];
  logic [5:0]  q_addr;
  int          checks = 0;
  int          errors = 0;
  int          cyc_cnt = 0;
  typedef struct {logic err; logic chk; logic [31:0] data; int cyc;} exp_t;
  exp_t sb[$];
  wb_soc_ram_slave #(.ADDR_WIDTH(6)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wb_cyc_i   (cyc),
    .wb_stb_i   (stb),
    .wb_we_i    (we),
    .wb_adr_i   (adr),
    .wb_sel_i   (sel),
    .wb_dat_i   (dat_i),
    .wb_dat_o   (dat_o),
    .wb_ack_o   (ack),
    .wb_err_o   (err),
    .ram_addr_o (ram_addr),
    .ram_data_o (ram_data),
    .ram_we_o   (ram_we),
    .ram_q_i    (ram_q)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    q_addr <= ram_addr;
  end
  assign ram_q = mem[q_addr];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (ack || err)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_resp: got ack=%0b err=%0b at cycle %0d expected no response", ack, err, cyc_cnt);
      end else begin
        e = sb.pop_front();
        chk("resp_err", {31'b0, err}, {31'b0, e.err});
        chk("resp_ack", {31'b0, ack}, {31'b0, !e.err});
        chk("resp_cycle", cyc_cnt, e.cyc);
        if (e.chk) chk("resp_data", dat_o, e.data);
      end
    end
  end
  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
  endtask
  task automatic expect_resp(input logic e_err, input logic e_chk, input logic [31:0] e_data);
    sb.push_back('{err: e_err, chk: e_chk, data: e_data, cyc: cyc_cnt + 2});
  endtask
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic e_err, input logic e_chk, input logic [31:0] e_data);
    @(negedge clk);
    drive(w, a, d, s);
    expect_resp(e_err, e_chk, e_data);
    @(negedge clk);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
  endtask
  logic alias_err;
  initial begin
`ifdef WB_SOC_RAM_SLAVE_ERR_EN
    alias_err = 1'b1;
`else
    alias_err = 1'b0;
`endif
    #3;
    chk("rst_dat", dat_o, 32'h0);
    chk("rst_ack", {31'b0, ack}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_we", {31'b0, ram_we}, 32'h0);
    #9 rst_n = 1'b1;
    xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 32'h0);
    chk("w4_full", mem[4], 32'hDEADBEEF);
    xfer(1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 1'b1, 32'hDEADBEEF);
    xfer(1'b1, 32'h10, 32'h11223344, 4'h5, 1'b0, 1'b0, 32'h0);
    chk("w4_sel0101", mem[4], 32'hDE22BE44);
    xfer(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 1'b0, 1'b0, 32'h0);
    chk("w4_sel0000", mem[4], 32'hDE22BE44);
    xfer(1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 1'b1, 32'hDE22BE44);
    xfer(1'b1, 32'h14, 32'h55AA55AA, 4'hF, 1'b0, 1'b0, 32'h0);
    chk("w5_full", mem[5], 32'h55AA55AA);
    @(negedge clk);
    drive(1'b1, 32'h14, 32'h12345678, 4'hF);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    #1 chk("abort_we", {31'b0, ram_we}, 32'h0);
    repeat (3) @(negedge clk);
    chk("w5_abort", mem[5], 32'h55AA55AA);
    @(negedge clk);
    drive(1'b0, 32'h14, 32'h0, 4'hF);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_dat", dat_o, 32'h0);
    chk("mid_rst_ack", {31'b0, ack}, 32'h0);
    chk("mid_rst_err", {31'b0, err}, 32'h0);
    chk("mid_rst_we", {31'b0, ram_we}, 32'h0);
    #1 rst_n = 1'b1;
    expect_resp(1'b0, 1'b1, 32'h55AA55AA);
    @(negedge clk);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    xfer(1'b1, 32'h0, 32'h0BADF00D, 4'hF, 1'b0, 1'b0, 32'h0);
    xfer(1'b1, 32'h100, 32'hCAFEF00D, 4'hF, alias_err, 1'b0, 32'h0);
    chk("w0_range", mem[0], alias_err ? 32'h0BADF00D : 32'hCAFEF00D);
    @(negedge clk);
    drive(1'b0, 32'h10, 32'h0, 4'hF);
    for (int i = 0; i < 10; i++)
      sb.push_back('{err: 1'b0, chk: 1'b1, data: 32'hDE22BE44, cyc: cyc_cnt + 2 + 3 * i});
    repeat (29) @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    xfer(1'b0, 32'h13, 32'h0, 4'hF, alias_err, !alias_err, 32'hDE22BE44);
    repeat (5) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_resp: got %0d outstanding responses expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
